// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: fetches sequentially from instruction memory, buffers up to DEPTH words
// and presents the head {instruction, PC+4} to IF/ID; redirects flush the queue and refetch.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData,
    output logic        instValid,
    output logic [31:0] inst,
    output logic [31:0] instPcPlus4,
    input  logic        instReady
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW+1:0] DEPTH_V = (PW+2)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } fetchStateT;

    fetchStateT  state;
    fetchStateT  stateNext;
    logic [PW:0]   count;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [31:0]   fetchPc;
    logic [31:0]   fetchPcNext;
    logic [31:0]   memAddrNext;
    logic          memReqNext;
    logic [31:0]   instMem [DEPTH];
    logic [31:0]   pcMem   [DEPTH];
    logic          push;
    logic          pop;
    logic [PW+1:0] nextCount;
    logic          roomNext;
    logic [31:0]   target;
    logic [31:0]   ackPcPlus4;

    assign target      = {redirectPc[31:2], 2'b00};
    assign ackPcPlus4  = memAddr + 32'd4;
    assign instValid   = (count != '0);
    assign inst        = instMem[rdPtr];
    assign instPcPlus4 = pcMem[rdPtr];

    // A redirect cancels both the pop and the push of its own cycle.
    assign pop       = instValid && instReady && !redirect;
    assign push      = (state == WAIT) && memAck && !redirect;
    assign nextCount = {1'b0, count} + {{(PW+1){1'b0}}, push} - {{(PW+1){1'b0}}, pop};
    assign roomNext  = (nextCount < DEPTH_V);

    always_comb begin
        stateNext   = state;
        memReqNext  = memReq;
        memAddrNext = memAddr;
        fetchPcNext = fetchPc;
        if (redirect) begin
            fetchPcNext = target;
            if (state == IDLE) begin
                stateNext   = WAIT;
                memReqNext  = 1'b1;
                memAddrNext = target;
            end else if (memAck) begin
                stateNext   = WAIT;
                memAddrNext = target;
            end else begin
                stateNext = DISCARD;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (roomNext) begin
                        stateNext   = WAIT;
                        memReqNext  = 1'b1;
                        memAddrNext = fetchPc;
                    end
                end
                WAIT: begin
                    if (memAck) begin
                        fetchPcNext = ackPcPlus4;
                        if (roomNext) begin
                            memAddrNext = ackPcPlus4;
                        end else begin
                            stateNext  = IDLE;
                            memReqNext = 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    // The stale word is dropped; fetchPc already holds the redirect target.
                    if (memAck) begin
                        stateNext   = WAIT;
                        memAddrNext = fetchPc;
                    end
                end
                default: begin
                    stateNext  = IDLE;
                    memReqNext = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            memReq  <= 1'b0;
            memAddr <= RESET_PC;
            fetchPc <= RESET_PC;
        end else begin
            state   <= stateNext;
            memReq  <= memReqNext;
            memAddr <= memAddrNext;
            fetchPc <= fetchPcNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instMem[i] <= '0;
                pcMem[i]   <= '0;
            end
        end else if (redirect) begin
            count <= '0;
            rdPtr <= '0;
            wrPtr <= '0;
        end else begin
            if (push) begin
                instMem[wrPtr] <= memData;
                pcMem[wrPtr]   <= ackPcPlus4;
                wrPtr          <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= nextCount[PW:0];
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomized bench for inst_prefetch_queue: a behavioural memory plus a transaction-level queue model
// predicts every fetch address, request level and head entry.
module tb_inst_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memData;
    logic        instValid;
    logic [31:0] inst;
    logic [31:0] instPcPlus4;
    logic        instReady;

    inst_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirectPc  (redirectPc),
        .memReq      (memReq),
        .memAddr     (memAddr),
        .memAck      (memAck),
        .memData     (memData),
        .instValid   (instValid),
        .inst        (inst),
        .instPcPlus4 (instPcPlus4),
        .instReady   (instReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pcPlus4;
    } entryT;

    entryT       modelQ[$];
    int          compared;
    int          mismatched;
    bit          pending;
    bit          pendStale;
    logic [31:0] pendAddr;
    int          pendWait;
    logic [31:0] expFetch;
    bit          expReq;
    int          minLat;
    int          maxLat;
    int          popped;
    bit          lastRedir;
    bit          lastAck;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    task automatic modelReset();
        modelQ.delete();
        pending   = 1'b0;
        pendStale = 1'b0;
        expFetch  = RESET_PC;
        expReq    = 1'b0;
    endtask

    // One clock of stimulus: check the state left by the last edge, play memory, advance the model.
    // redirMode: 0 never, 1 always, 2 only with an ack, 3 only while a request waits without ack.
    task automatic applyStimulus(input bit ready, input int redirMode, input logic [31:0] target,
                                 input bit strayAck);
        bit    ack;
        bit    doRedir;
        bit    reqHeld;
        entryT h;
        compared++;
        if (memReq !== expReq) begin
            mismatched++;
            $display("[TB] FAIL memReq: got %b expected %b at %0t", memReq, expReq, $time);
        end
        compared++;
        if (instValid !== (modelQ.size() != 0)) begin
            mismatched++;
            $display("[TB] FAIL instValid: got %b expected %b at %0t", instValid, modelQ.size() != 0, $time);
        end
        if (modelQ.size() != 0) begin
            h = modelQ[0];
            compared++;
            if (inst !== h.data) begin
                mismatched++;
                $display("[TB] FAIL inst: got %h expected %h at %0t", inst, h.data, $time);
            end
            compared++;
            if (instPcPlus4 !== h.pcPlus4) begin
                mismatched++;
                $display("[TB] FAIL instPcPlus4: got %h expected %h at %0t", instPcPlus4, h.pcPlus4, $time);
            end
        end
        if (!pending && memReq === 1'b1) begin
            pending   = 1'b1;
            pendStale = 1'b0;
            pendAddr  = memAddr;
            pendWait  = $urandom_range(maxLat, minLat);
            compared++;
            if (memAddr !== expFetch) begin
                mismatched++;
                $display("[TB] FAIL fetchAddr: got %h expected %h at %0t", memAddr, expFetch, $time);
            end
        end else if (pending) begin
            compared++;
            if (memAddr !== pendAddr) begin
                mismatched++;
                $display("[TB] FAIL addrHold: got %h expected %h at %0t", memAddr, pendAddr, $time);
            end
        end
        ack = pending && (pendWait == 0);
        if (pending && pendWait > 0) pendWait--;
        case (redirMode)
            1:       doRedir = 1'b1;
            2:       doRedir = ack;
            3:       doRedir = pending && !ack;
            default: doRedir = 1'b0;
        endcase
        memAck     = ack || strayAck;
        memData    = ack ? memWord(pendAddr) : $urandom;
        redirect   = doRedir;
        redirectPc = target;
        instReady  = ready;
        lastRedir  = doRedir;
        lastAck    = ack;
        reqHeld    = pending && !ack;
        @(posedge clk);
        #1;
        if (doRedir) begin
            modelQ.delete();
            expFetch = {target[31:2], 2'b00};
            if (ack) pending = 1'b0;
            else pendStale = 1'b1;
        end else begin
            if (ready && modelQ.size() != 0) begin
                void'(modelQ.pop_front());
                popped++;
            end
            if (ack) begin
                pending = 1'b0;
                if (!pendStale) begin
                    compared++;
                    if (modelQ.size() >= DEPTH) begin
                        mismatched++;
                        $display("[TB] FAIL overflow: got %0d entries before push, limit %0d", modelQ.size(), DEPTH);
                    end else begin
                        modelQ.push_back('{data: memWord(pendAddr), pcPlus4: pendAddr + 32'd4});
                    end
                    expFetch = pendAddr + 32'd4;
                end
            end
        end
        expReq = doRedir || reqHeld || (modelQ.size() < DEPTH);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (memReq !== 1'b0) begin mismatched++; $display("[TB] FAIL resetMemReq: got %b expected 0", memReq); end
        compared++;
        if (memAddr !== RESET_PC) begin mismatched++; $display("[TB] FAIL resetMemAddr: got %h expected %h", memAddr, RESET_PC); end
        compared++;
        if (instValid !== 1'b0) begin mismatched++; $display("[TB] FAIL resetInstValid: got %b expected 0", instValid); end
        compared++;
        if (inst !== 32'h0) begin mismatched++; $display("[TB] FAIL resetInst: got %h expected 0", inst); end
        compared++;
        if (instPcPlus4 !== 32'h0) begin mismatched++; $display("[TB] FAIL resetPcPlus4: got %h expected 0", instPcPlus4); end
        rst = 1'b1;
        modelReset();
    endtask

    task automatic test_stream();
        minLat = 0;
        maxLat = 0;
        popped = 0;
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 0, 32'h0, 1'b0);
        compared++;
        if (popped != 28) begin
            mismatched++;
            $display("[TB] FAIL streamRate: got %0d pops expected 28", popped);
        end
    endtask

    task automatic test_fill_drain();
        minLat = 0;
        maxLat = 0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 0, 32'h0, 1'b0);
        compared++;
        if (memReq !== 1'b0) begin mismatched++; $display("[TB] FAIL fullStall: got memReq %b expected 0", memReq); end
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 0, 32'h0, 1'b0);
    endtask

    task automatic test_redirect_wait();
        minLat = 3;
        maxLat = 3;
        lastRedir = 1'b0;
        for (int i = 0; i < 40 && !lastRedir; i++) applyStimulus(1'b1, 3, 32'h100, 1'b0);
        compared++;
        if (!lastRedir) begin mismatched++; $display("[TB] FAIL redirWaitSetup: got no redirect expected one"); end
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 0, 32'h0, 1'b0);
    endtask

    task automatic test_redirect_ack();
        minLat = 1;
        maxLat = 1;
        lastRedir = 1'b0;
        for (int i = 0; i < 40 && !lastRedir; i++) applyStimulus(1'b1, 2, 32'h203, 1'b0);
        compared++;
        if (memAddr !== 32'h200) begin mismatched++; $display("[TB] FAIL redirAckAddr: got %h expected 00000200", memAddr); end
        compared++;
        if (instValid !== 1'b0) begin mismatched++; $display("[TB] FAIL redirAckFlush: got %b expected 0", instValid); end
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 0, 32'h0, 1'b0);
    endtask

    task automatic test_full_pushpop();
        bit hit;
        minLat = 0;
        maxLat = 0;
        hit = 1'b0;
        applyStimulus(1'b1, 1, 32'h400, 1'b0);
        for (int i = 0; i < 20 && !hit; i++) begin
            if (modelQ.size() == DEPTH - 1 && memReq === 1'b1) begin
                applyStimulus(1'b1, 0, 32'h0, 1'b0);
                hit = lastAck;
            end else begin
                applyStimulus(1'b0, 0, 32'h0, 1'b0);
            end
        end
        compared++;
        if (!hit) begin mismatched++; $display("[TB] FAIL pushPopSetup: got no push+pop at count %0d", DEPTH - 1); end
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 0, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        minLat = 0;
        maxLat = 3;
        for (int i = 0; i < 800; i++) begin
            tgt = ($urandom_range(1, 0) == 1) ? (32'hFFFFFFE8 + $urandom_range(23, 0)) : $urandom;
            applyStimulus(($urandom_range(3, 0) != 0), ($urandom_range(19, 0) == 0) ? 1 : 0, tgt, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        minLat = 2;
        maxLat = 2;
        hit = 1'b0;
        applyStimulus(1'b1, 1, 32'h40, 1'b0);
        for (int i = 0; i < 30 && !hit; i++) begin
            if (modelQ.size() == 2 && memReq === 1'b1) hit = 1'b1;
            else applyStimulus(1'b0, 0, 32'h0, 1'b0);
        end
        compared++;
        if (!hit) begin mismatched++; $display("[TB] FAIL resetMidSetup: got no count=2 with memReq"); end
        #2 rst = 1'b0;
        #1;
        compared++;
        if (memReq !== 1'b0) begin mismatched++; $display("[TB] FAIL asyncMemReq: got %b expected 0", memReq); end
        compared++;
        if (instValid !== 1'b0) begin mismatched++; $display("[TB] FAIL asyncInstValid: got %b expected 0", instValid); end
        memAck   = 1'b0;
        redirect = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        modelReset();
        compared++;
        if (memAddr !== RESET_PC) begin mismatched++; $display("[TB] FAIL releaseMemAddr: got %h expected %h", memAddr, RESET_PC); end
        minLat = 0;
        maxLat = 1;
        applyStimulus(1'b1, 0, 32'h0, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 0, 32'h0, 1'b0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        popped     = 0;
        redirect   = 1'b0;
        redirectPc = 32'h0;
        memAck     = 1'b0;
        memData    = 32'h0;
        instReady  = 1'b0;
        minLat     = 0;
        maxLat     = 0;
        modelReset();
        test_reset();
        test_stream();
        test_fill_drain();
        test_redirect_wait();
        test_redirect_ack();
        test_full_pushpop();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
